data_sync_launcher: RTL and testbench
=====================================

Name: data_sync_launcher

Overview:
- Source-side launcher for a two-flop multi-bit data synchronizer.
- Accepts a word through a valid/ready handshake, registers it onto a held-stable bus, and drives a level enable.
- The destination domain synchronizes the enable and captures the bus when it sees the enable rise.
- Enable timing is either fixed, using programmed hold and gap counts, or set by a 4-phase acknowledge returned from the destination domain and synchronized locally.

Parameters:
- BUS_WIDTH, 8: width of the data word and launched bus.
- NUM_STAGES, 2: number of synchronizer flops on i_bus_ack. Legal range 2..4.
- USE_ACK, 0: 0 = timed mode. 1 = 4-phase acknowledge mode.
- ENABLE_CYCLES, 4: timed mode only. Cycles o_bus_enable stays high. Must be >= NUM_STAGES+2.
- GAP_CYCLES, 4: timed mode only. Cycles o_bus_enable stays low before the next launch. Must be >= NUM_STAGES+2.

Ports:
- i_CLK, input, 1: source clock.
- i_RST, input, 1: asynchronous active-high reset.
- i_data, input, BUS_WIDTH: word to launch.
- i_data_valid, input, 1: i_data is valid.
- o_data_ready, output, 1: launcher can accept a word.
- i_bus_ack, input, 1: acknowledge from the destination domain. Asynchronous. Ignored when USE_ACK=0.
- o_unsync_bus, output, BUS_WIDTH: registered bus to the destination synchronizer.
- o_bus_enable, output, 1: registered level enable to the destination synchronizer.
- o_done, output, 1: one-cycle pulse when a transfer completes.

Behaviour:
- Reset values (all asynchronous, on i_RST high):
  - state = IDLE, o_bus_enable = 0, o_unsync_bus = 0, o_done = 0.
  - Counters = 0, ack synchronizer flops = 0.
  - o_data_ready = 0 while i_RST is high.
- All outputs are registers, except o_data_ready, which is decoded from state:
  - USE_ACK=0: o_data_ready = (state == IDLE).
  - USE_ACK=1: o_data_ready = (state == IDLE) && !ack_sync.
- ack_sync is the output of a NUM_STAGES flop chain on i_bus_ack, reset to 0.
- States: IDLE, REQ, RELEASE.
- IDLE:
  - Accept occurs on a clock edge where i_data_valid && o_data_ready.
  - On accept: o_unsync_bus <= i_data, o_bus_enable <= 1, state <= REQ, counter cleared.
  - The bus and enable therefore change on the same edge; latency from accept to enable is 1 edge.
  - Receiver requirement: capture only after its synchronized enable, which settles NUM_STAGES edges later in its domain, so bus setup is guaranteed.
- REQ, timed mode: the counter increments each cycle. After o_bus_enable has been high for exactly ENABLE_CYCLES cycles: o_bus_enable <= 0, state <= RELEASE, counter cleared.
- REQ, ack mode: hold until ack_sync == 1. Then o_bus_enable <= 0, state <= RELEASE. There is no timeout; REQ holds indefinitely.
- RELEASE, timed mode: after exactly GAP_CYCLES low cycles, state <= IDLE and o_done <= 1 for one cycle.
- RELEASE, ack mode: when ack_sync == 0, state <= IDLE and o_done <= 1 for one cycle.
- o_unsync_bus is stable (never updates) from one accept through the end of RELEASE. It changes only on an accept edge.
- i_data and i_data_valid are ignored outside IDLE, and in IDLE while o_data_ready = 0.
- In ack mode, an ack still high when IDLE is entered blocks acceptance until ack_sync falls. Data is never launched under a stale ack.
- Back-to-back: the next accept is no earlier than the first IDLE cycle, at the edge after o_done is asserted.
- Reset mid-transfer:
  - o_bus_enable drops immediately, with no clock needed.
  - The in-flight word is dropped and o_done is not pulsed.
  - After reset release, the block is in IDLE.
- Counter width: clog2(max(ENABLE_CYCLES, GAP_CYCLES)+1). The counter never wraps in normal operation.

Test Plan:
- Reset/idle:
  - Stimulus: hold i_RST=1, then release.
  - Required: o_bus_enable=0, o_unsync_bus=0x00, o_done=0; o_data_ready=1 on the first cycle after release (USE_ACK=0).
- Timed single transfer (defaults):
  - Stimulus: i_data=0xA5 with valid, accepted at edge k.
  - Required: o_unsync_bus=0xA5 and o_bus_enable=1 after edge k; enable high for exactly 4 cycles and falls at edge k+4; low 4 cycles; o_done high for exactly one cycle after edge k+8; bus holds 0xA5 throughout.
- Timed back-to-back:
  - Stimulus: valid held continuously with 0x11 then 0x22.
  - Required: second accept at edge k+9; o_unsync_bus changes 0x11->0x22 only at that edge; enable rises exactly twice.
- Ack mode (USE_ACK=1):
  - Stimulus: launch 0x3C; i_bus_ack rises 3 cycles after enable and falls 3 cycles after enable falls.
  - Required: enable falls NUM_STAGES+1 edges after ack rises; o_done pulses NUM_STAGES+1 edges after ack falls; bus = 0x3C throughout.
- Ack stuck/stale (USE_ACK=1):
  - Stimulus: i_bus_ack=1 while IDLE with valid high.
  - Required: o_data_ready=0, no launch; launch occurs 1 edge after ack_sync falls.
- Reset mid-REQ:
  - Stimulus: assert i_RST two cycles into REQ.
  - Required: o_bus_enable=0 asynchronously, o_done never pulses, IDLE after release.

Source files
------------

// File: rtl/data_sync_launcher.sv
// data_sync_launcher
//   Source-side launcher for a two-flop multi-bit synchronizer. A word accepted over
//   valid/ready is registered onto a bus that is held stable. A level enable is raised
//   on the same edge as the bus update. The destination synchronizes the enable and
//   captures the bus when it sees the enable rise. The enable timing is set in one of
//   two ways:
//   - Timed mode (USE_ACK=0): the enable stays high for ENABLE_CYCLES cycles, then low
//     for GAP_CYCLES cycles.
//   - Ack mode (USE_ACK=1): a 4-phase handshake on i_bus_ack, synchronized locally.
//
// Ports
//   i_CLK, i_RST   source clock, asynchronous active-high reset
//   i_data         word to launch
//   i_data_valid   i_data is valid
//   o_data_ready   launcher can accept a word (decoded from state)
//   i_bus_ack      asynchronous acknowledge from destination (ack mode only)
//   o_unsync_bus   registered bus to the destination synchronizer
//   o_bus_enable   registered level enable to the destination synchronizer
//   o_done         one-cycle pulse when a transfer completes
module data_sync_launcher #(
    parameter int unsigned BUS_WIDTH     = 8,
    parameter int unsigned NUM_STAGES    = 2,
    parameter int unsigned USE_ACK       = 0,
    parameter int unsigned ENABLE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 4
) (
    input  logic                 i_CLK,
    input  logic                 i_RST,
    input  logic [BUS_WIDTH-1:0] i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    input  logic                 i_bus_ack,
    output logic [BUS_WIDTH-1:0] o_unsync_bus,
    output logic                 o_bus_enable,
    output logic                 o_done
);

    localparam bit          AckMode   = (USE_ACK != 0);
    localparam int unsigned MaxCycles = (ENABLE_CYCLES > GAP_CYCLES) ? ENABLE_CYCLES
                                                                     : GAP_CYCLES;
    localparam int unsigned CntWidth  = $clog2(MaxCycles + 1);

    // Terminal counts: the counter restarts at 0 on the edge that enters each phase.
    localparam logic [CntWidth-1:0] EnableLast = CntWidth'(ENABLE_CYCLES - 1);
    localparam logic [CntWidth-1:0] GapLast    = CntWidth'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRelease
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]  bus_q, bus_d;
    logic                  enable_q, enable_d;
    logic                  done_q, done_d;
    logic [NUM_STAGES-1:0] ack_sync_q;
    logic                  ack_sync;
    logic                  accept;

    assign ack_sync = ack_sync_q[NUM_STAGES-1];

    // In ack mode, a stale ack still high from the previous transfer holds off acceptance.
    assign o_data_ready = (state_q == StIdle) && !i_RST && !(AckMode && ack_sync);
    assign accept       = i_data_valid && o_data_ready;

    assign o_unsync_bus = bus_q;
    assign o_bus_enable = enable_q;
    assign o_done       = done_q;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], i_bus_ack};
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bus_q    <= '0;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            enable_q <= enable_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bus_d    = bus_q;
        enable_d = enable_q;
        done_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // Bus and enable change together; the receiver's enable synchronizer
                // provides the bus setup margin.
                if (accept) begin
                    bus_d    = i_data;
                    enable_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (AckMode) begin
                    if (ack_sync) begin
                        enable_d = 1'b0;
                        state_d  = StRelease;
                    end
                end else if (cnt_q == EnableLast) begin
                    enable_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRelease;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (AckMode) begin
                    if (!ack_sync) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (cnt_q == GapLast) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_data_sync_launcher.sv
// Bench for data_sync_launcher. It runs two instances side by side, one in timed mode
// and one in ack mode, and checks both against a behavioural model on every cycle.
// Directed scenarios add literal timing expectations.
module tb_data_sync_launcher;

    localparam int EN  = 4;
    localparam int GAP = 4;
    localparam int NS  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] data_t = '0;
    logic       valid_t = 1'b0;
    logic       rdy_t, en_t, done_t;
    logic [7:0] bus_t;

    logic [7:0] data_a = '0;
    logic       valid_a = 1'b0;
    logic       ack_a = 1'b0;
    logic       rdy_a, en_a, done_a;
    logic [7:0] bus_a;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    data_sync_launcher #(
        .BUS_WIDTH(8), .NUM_STAGES(NS), .USE_ACK(0), .ENABLE_CYCLES(EN), .GAP_CYCLES(GAP)
    ) dut_t (
        .i_CLK(clk), .i_RST(rst), .i_data(data_t), .i_data_valid(valid_t),
        .o_data_ready(rdy_t), .i_bus_ack(1'b0), .o_unsync_bus(bus_t),
        .o_bus_enable(en_t), .o_done(done_t)
    );

    data_sync_launcher #(
        .BUS_WIDTH(8), .NUM_STAGES(NS), .USE_ACK(1), .ENABLE_CYCLES(EN), .GAP_CYCLES(GAP)
    ) dut_a (
        .i_CLK(clk), .i_RST(rst), .i_data(data_a), .i_data_valid(valid_a),
        .o_data_ready(rdy_a), .i_bus_ack(ack_a), .o_unsync_bus(bus_a),
        .o_bus_enable(en_a), .o_done(done_a)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ------------------------------------------------------------------
    // Behavioural model.
    // Timed: everything follows from the accept edge number.
    // Ack: the synchronized ack is the raw ack sampled NS-1 edges earlier.
    // ------------------------------------------------------------------
    int         tm_e = 0;
    int         tm_acc = -1;
    logic [7:0] tm_bus = '0;
    logic       exp_t_en = 1'b0, exp_t_done = 1'b0, exp_t_rdy = 1'b1;

    int         am_stage = 0;  // 0 waiting for word, 1 enable high, 2 enable low
    logic       am_sync = 1'b0;
    logic       am_prev;
    bit         am_hist[$];
    logic [7:0] am_bus = '0;
    logic       exp_a_en = 1'b0, exp_a_done = 1'b0, exp_a_rdy = 1'b1;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            tm_e = 0; tm_acc = -1; tm_bus = '0;
            exp_t_en = 1'b0; exp_t_done = 1'b0; exp_t_rdy = 1'b1;
            am_stage = 0; am_sync = 1'b0; am_hist.delete(); am_bus = '0;
            exp_a_en = 1'b0; exp_a_done = 1'b0; exp_a_rdy = 1'b1;
        end else begin
            tm_e++;
            if ((tm_acc < 0 || tm_e - 1 - tm_acc >= EN + GAP) && valid_t) begin
                tm_acc = tm_e;
                tm_bus = data_t;
            end
            exp_t_en   = (tm_acc >= 0) && (tm_e - tm_acc < EN);
            exp_t_done = (tm_acc >= 0) && (tm_e - tm_acc == EN + GAP);
            exp_t_rdy  = (tm_acc < 0) || (tm_e - tm_acc >= EN + GAP);

            am_prev = am_sync;
            am_hist.push_back(ack_a);
            if (am_hist.size() > NS) void'(am_hist.pop_front());
            am_sync = (am_hist.size() == NS) ? am_hist[0] : 1'b0;
            exp_a_done = 1'b0;
            if (am_stage == 0) begin
                if (!am_prev && valid_a) begin
                    am_stage = 1;
                    am_bus   = data_a;
                end
            end else if (am_stage == 1) begin
                if (am_prev) am_stage = 2;
            end else if (!am_prev) begin
                am_stage   = 0;
                exp_a_done = 1'b1;
            end
            exp_a_en  = (am_stage == 1);
            exp_a_rdy = (am_stage == 0) && !am_sync;
        end
    end

    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            check("t_enable", en_t, exp_t_en);
            check("t_done", done_t, exp_t_done);
            check("t_ready", rdy_t, exp_t_rdy);
            check("t_bus", bus_t, tm_bus);
            check("a_enable", en_a, exp_a_en);
            check("a_done", done_a, exp_a_done);
            check("a_ready", rdy_a, exp_a_rdy);
            check("a_bus", bus_a, am_bus);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        int fall_i, done_i, done_cnt, bus_bad, chg_i, rises, rise_i, en_seen;
        logic prev_en;

        // Reset / idle
        repeat (3) @(posedge clk);
        #2;
        check("rst_enable", en_t, 1'b0);
        check("rst_bus", bus_t, 8'h00);
        check("rst_done", done_t, 1'b0);
        check("rst_ready_t", rdy_t, 1'b0);
        check("rst_ready_a", rdy_a, 1'b0);
        rst = 1'b0;
        #1;
        check("rel_ready_t", rdy_t, 1'b1);
        check("rel_ready_a", rdy_a, 1'b1);
        cmp_en = 1'b1;
        tick();

        // Timed single transfer
        valid_t = 1'b1; data_t = 8'hA5;
        tick();
        valid_t = 1'b0;
        check("single_bus", bus_t, 8'hA5);
        check("single_en", en_t, 1'b1);
        fall_i = -1; done_i = -1; done_cnt = 0; bus_bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!en_t && fall_i < 0) fall_i = i;
            if (done_t) begin
                done_cnt++;
                if (done_i < 0) done_i = i;
            end
            if (bus_t !== 8'hA5) bus_bad++;
        end
        check("single_fall_edge", fall_i, 3);
        check("single_done_edge", done_i, 7);
        check("single_done_width", done_cnt, 1);
        check("single_bus_stable", bus_bad, 0);

        // Timed back-to-back
        prev_en = en_t; rises = 0; chg_i = -1;
        valid_t = 1'b1; data_t = 8'h11;
        tick();
        if (en_t && !prev_en) rises++;
        prev_en = en_t;
        check("b2b_first_bus", bus_t, 8'h11);
        data_t = 8'h22;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (en_t && !prev_en) rises++;
            prev_en = en_t;
            if (bus_t == 8'h22 && chg_i < 0) begin
                chg_i   = i;
                valid_t = 1'b0;
            end
        end
        check("b2b_second_accept", chg_i, 8);
        check("b2b_enable_rises", rises, 2);
        repeat (4) tick();

        // Ack mode transfer
        valid_a = 1'b1; data_a = 8'h3C;
        tick();
        valid_a = 1'b0;
        check("ack_launch_en", en_a, 1'b1);
        repeat (3) tick();
        ack_a = 1'b1;
        fall_i = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!en_a) begin
                fall_i = i;
                break;
            end
        end
        check("ack_fall_delay", fall_i, NS);
        repeat (3) tick();
        ack_a = 1'b0;
        done_i = -1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_a) begin
                done_i = i;
                break;
            end
        end
        check("ack_done_delay", done_i, NS);
        check("ack_bus", bus_a, 8'h3C);
        repeat (2) tick();

        // Stale ack blocks launch
        ack_a = 1'b1;
        repeat (3) tick();
        check("stale_ready", rdy_a, 1'b0);
        valid_a = 1'b1; data_a = 8'h5A;
        en_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (en_a) en_seen++;
        end
        check("stale_no_launch", en_seen, 0);
        ack_a = 1'b0;
        rise_i = -1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (en_a) begin
                rise_i = i;
                break;
            end
        end
        check("stale_launch_edge", rise_i, NS);
        check("stale_bus", bus_a, 8'h5A);
        valid_a = 1'b0;
        ack_a = 1'b1;
        repeat (6) tick();
        ack_a = 1'b0;
        repeat (6) tick();

        // Reset mid-REQ
        valid_t = 1'b1; data_t = 8'h77;
        tick();
        valid_t = 1'b0;
        repeat (2) tick();
        check("midreq_en_before", en_t, 1'b1);
        rst = 1'b1;
        #1;
        check("midreq_async_en", en_t, 1'b0);
        check("midreq_async_bus", bus_t, 8'h00);
        check("midreq_ready", rdy_t, 1'b0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("midreq_idle_ready", rdy_t, 1'b1);
        done_cnt = 0; en_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_t) done_cnt++;
            if (en_t) en_seen++;
        end
        check("midreq_no_done", done_cnt, 0);
        check("midreq_no_enable", en_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
